// File: rtl/stack_ctrl.sv
// ----------------------------------------------------------------------------
// stack_ctrl
// Sequencer/arbiter for the byte-addressed stack memory. Owns ESP and shares
// the memory between requester A (core execute stage) and requester B
// (interrupt/exception unit). Every op walks IDLE -> EXEC -> RESP, so each
// request completes in exactly three cycles.
//
// Ports
//   clock, reset                  system clock, synchronous active-high reset
//   a_req/a_op/a_addr/a_wdata     requester A: valid, op code, address, data
//   b_req/b_op/b_addr/b_wdata     requester B: same as A
//   a_ack, b_ack                  one-cycle completion pulse per requester
//   rsp_rdata, rsp_err            POP/LOAD data and reject flag, valid with ack
//   mem_op                        4'h1 write at mem_esp, 4'h8 write at mem_addr
//   mem_esp, mem_addr, mem_wdata  memory addresses and write data
//   mem_esp_data, mem_addr_data   combinational read words from memory
//   esp, stk_empty, stk_full      stack pointer and its boundary flags
//   busy                          FSM not IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, latch winner's op/addr/wdata
// EXEC  | range-check, drive memory, update ESP / read data
// RESP  | pulse ack of granted requester, response held stable
// ----------------------------------------------------------------------------
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP = 32'h0000_0200,
    parameter logic [31:0] STACK_LOW = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic [2:0]  a_op,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic [2:0]  b_op,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  mem_op,
    output logic [31:0] mem_esp,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_esp_data,
    input  logic [31:0] mem_addr_data,
    output logic [31:0] esp,
    output logic        stk_empty,
    output logic        stk_full,
    output logic        busy
);

    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_STORE  = 3'd4;
    localparam logic [2:0] OP_SETESP = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] esp_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  op_q;
    logic        last_b_q;
    logic        a_ack_q;
    logic        b_ack_q;
    logic        err_q;

    logic        pick_b;
    logic [31:0] addr_off;
    logic [31:0] new_off;
    logic        addr_ok;
    logic        esp_ok;
    logic        op_err;

    // B has priority, but yields once to A right after it was served.
    assign pick_b = b_req && !(last_b_q && a_req);

    // Offsets from STACK_LOW wrap to huge values when below it, so one
    // unsigned compare covers both ends of each range.
    assign addr_off = addr_q - STACK_LOW;
    assign new_off  = wdata_q - STACK_LOW;
    assign addr_ok  = (addr_q[1:0] == 2'b00) &&
                      (addr_off <= (STACK_TOP - 32'd4 - STACK_LOW));
    assign esp_ok   = (wdata_q[1:0] == 2'b00) &&
                      (new_off <= (STACK_TOP - STACK_LOW));

    always_comb begin
        op_err = 1'b0;
        case (op_q)
            OP_PUSH:           op_err = (esp_q == STACK_LOW);
            OP_POP:            op_err = (esp_q == STACK_TOP);
            OP_LOAD, OP_STORE: op_err = !addr_ok;
            OP_SETESP:         op_err = !esp_ok;
            default:           op_err = 1'b1;
        endcase
    end

    // Memory strobes are gated by reset so an aborted op never writes.
    always_comb begin
        mem_op  = 4'h0;
        mem_esp = esp_q;
        if (state_q == EXEC && !op_err) begin
            if (op_q == OP_PUSH) begin
                mem_esp = esp_q - 32'd4;
                if (!reset) mem_op = 4'h1;
            end else if (op_q == OP_STORE && !reset) begin
                mem_op = 4'h8;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign esp       = esp_q;
    assign stk_empty = (esp_q == STACK_TOP);
    assign stk_full  = (esp_q == STACK_LOW);
    assign busy      = (state_q != IDLE);
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            esp_q    <= STACK_TOP;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            op_q     <= 3'd0;
            last_b_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        state_q  <= EXEC;
                        last_b_q <= pick_b;
                        op_q     <= pick_b ? b_op    : a_op;
                        addr_q   <= pick_b ? b_addr  : a_addr;
                        wdata_q  <= pick_b ? b_wdata : a_wdata;
                    end
                end
                EXEC: begin
                    state_q <= RESP;
                    err_q   <= op_err;
                    a_ack_q <= !last_b_q;
                    b_ack_q <= last_b_q;
                    case (op_q)
                        OP_PUSH: if (!op_err) esp_q <= esp_q - 32'd4;
                        OP_POP: begin
                            if (op_err) begin
                                rdata_q <= 32'h0;
                            end else begin
                                rdata_q <= mem_esp_data;
                                esp_q   <= esp_q + 32'd4;
                            end
                        end
                        OP_LOAD:   rdata_q <= op_err ? 32'h0 : mem_addr_data;
                        OP_SETESP: if (!op_err) esp_q <= wdata_q;
                        default: ;
                    endcase
                end
                RESP: begin
                    state_q <= IDLE;
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, b_req;
    logic [2:0]  a_op, b_op;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_ack, b_ack, rsp_err, stk_empty, stk_full, busy;
    logic [31:0] rsp_rdata, mem_esp, mem_addr, mem_wdata, esp;
    logic [31:0] mem_esp_data, mem_addr_data;
    logic [3:0]  mem_op;

    always #5 clock = ~clock;

    stack_ctrl dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_op(mem_op), .mem_esp(mem_esp), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_esp_data(mem_esp_data), .mem_addr_data(mem_addr_data),
        .esp(esp), .stk_empty(stk_empty), .stk_full(stk_full), .busy(busy)
    );

    // Stack memory attached to the DUT (128 words, 0x000..0x1FC).
    logic [31:0] tb_mem [0:127] = '{default: 32'h0};
    assign mem_esp_data  = (mem_esp  < 32'h200) ? tb_mem[mem_esp[8:2]]  : 32'h0;
    assign mem_addr_data = (mem_addr < 32'h200) ? tb_mem[mem_addr[8:2]] : 32'h0;
    always @(posedge clock) begin
        if (mem_op == 4'h1 && mem_esp < 32'h200) tb_mem[mem_esp[8:2]] <= mem_wdata;
        else if (mem_op == 4'h8 && mem_addr < 32'h200) tb_mem[mem_addr[8:2]] <= mem_wdata;
    end

    // Reference model: word array plus ESP, response and fairness state.
    logic [31:0] ref_mem [0:127];
    logic [31:0] ref_esp, ref_rdata;
    bit          ref_err, ref_last_b;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_a(input logic [2:0] op, input logic [31:0] ad, input logic [31:0] wd);
        a_req = 1'b1; a_op = op; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic [2:0] op, input logic [31:0] ad, input logic [31:0] wd);
        b_req = 1'b1; b_op = op; b_addr = ad; b_wdata = wd;
    endtask

    task automatic model_reset();
        ref_esp = 32'h200; ref_rdata = 32'h0; ref_err = 1'b0; ref_last_b = 1'b0;
    endtask

    function automatic logic [2:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 3'd1;
        if (r < 6) return 3'd2;
        if (r == 6) return 3'd3;
        if (r == 7) return 3'd4;
        if (r == 8) return 3'd5;
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h210));
    endfunction

    // Called with the DUT in IDLE and at least one request presented.
    // Returns in IDLE one cycle after the ack pulse.
    task automatic run_txn(output bit got_b);
        bit          win_b, e;
        logic [2:0]  op;
        logic [31:0] ad, wd, old_esp;
        logic [3:0]  xmop;
        win_b   = b_req && !(ref_last_b && a_req);
        op      = win_b ? b_op    : a_op;
        ad      = win_b ? b_addr  : a_addr;
        wd      = win_b ? b_wdata : a_wdata;
        old_esp = ref_esp;
        e       = 1'b0;
        xmop    = 4'h0;
        case (op)
            3'd1: if (ref_esp == 32'h0) e = 1'b1;
                  else begin
                      ref_esp = ref_esp - 32'd4;
                      ref_mem[ref_esp[8:2]] = wd;
                      xmop = 4'h1;
                  end
            3'd2: if (ref_esp == 32'h200) begin e = 1'b1; ref_rdata = 32'h0; end
                  else begin
                      ref_rdata = ref_mem[ref_esp[8:2]];
                      ref_esp = ref_esp + 32'd4;
                  end
            3'd3: if (ad[1:0] != 2'b00 || ad > 32'h1FC) begin e = 1'b1; ref_rdata = 32'h0; end
                  else ref_rdata = ref_mem[ad[8:2]];
            3'd4: if (ad[1:0] != 2'b00 || ad > 32'h1FC) e = 1'b1;
                  else begin ref_mem[ad[8:2]] = wd; xmop = 4'h8; end
            3'd5: if (wd[1:0] != 2'b00 || wd > 32'h200) e = 1'b1;
                  else ref_esp = wd;
            default: e = 1'b1;
        endcase
        ref_err    = e;
        ref_last_b = win_b;

        @(posedge clock); #1;
        chk("busy_exec", busy, 1);
        chk("mem_op_exec", mem_op, xmop);
        if (xmop == 4'h1) begin
            chk("mem_esp_push", mem_esp, old_esp - 32'd4);
            chk("mem_wdata_push", mem_wdata, wd);
        end
        if (xmop == 4'h8) begin
            chk("mem_addr_store", mem_addr, ad);
            chk("mem_wdata_store", mem_wdata, wd);
        end

        @(posedge clock); #1;
        chk("a_ack_resp", a_ack, !win_b);
        chk("b_ack_resp", b_ack, win_b);
        chk("rsp_err", rsp_err, ref_err);
        chk("rsp_rdata", rsp_rdata, ref_rdata);
        chk("esp", esp, ref_esp);
        chk("stk_empty", stk_empty, ref_esp == 32'h200);
        chk("stk_full", stk_full, ref_esp == 32'h0);
        chk("mem_op_resp", mem_op, 0);
        got_b = b_ack;

        @(posedge clock); #1;
        chk("a_ack_idle", a_ack, 0);
        chk("b_ack_idle", b_ack, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gb, prev_b;
        logic [31:0] saved;

        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        reset = 1'b1;
        a_req = 1'b0; a_op = 3'd0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_op = 3'd0; b_addr = 32'h0; b_wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_esp", esp, 32'h200);
        chk("rst_mem_op", mem_op, 0);
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", stk_empty, 1);
        chk("rst_full", stk_full, 0);
        @(posedge clock); #1;
        chk("idle_no_req", busy, 0);

        // PUSH then POP
        set_a(3'd1, 32'h0, 32'hDEADBEEF);
        run_txn(gb); a_req = 1'b0;
        chk("push_esp", esp, 32'h1FC);
        set_a(3'd2, 32'h0, 32'h0);
        run_txn(gb); a_req = 1'b0;
        chk("pop_data", rsp_rdata, 32'hDEADBEEF);
        chk("pop_empty", stk_empty, 1);

        // Empty and full boundaries
        set_a(3'd2, 32'h0, 32'h0);
        run_txn(gb); a_req = 1'b0;
        chk("pop_empty_err", rsp_err, 1);
        for (int i = 0; i < 128; i++) begin
            set_a(3'd1, 32'h0, $urandom);
            run_txn(gb); a_req = 1'b0;
        end
        chk("full_flag", stk_full, 1);
        set_a(3'd1, 32'h0, 32'h12345678);
        run_txn(gb); a_req = 1'b0;
        chk("push_full_err", rsp_err, 1);
        for (int i = 0; i < 128; i++) begin
            set_a(3'd2, 32'h0, 32'h0);
            run_txn(gb); a_req = 1'b0;
        end

        // Both requesters held: grants must alternate
        set_a(3'd1, 32'h0, 32'hAAAA0001);
        set_b(3'd1, 32'h0, 32'hBBBB0001);
        prev_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_txn(gb);
            if (i > 0) chk("alternate", gb, !prev_b);
            prev_b = gb;
        end
        a_req = 1'b0; b_req = 1'b0;

        // STORE/LOAD and address checks
        set_b(3'd4, 32'h40, 32'h11223344);
        run_txn(gb); b_req = 1'b0;
        set_b(3'd3, 32'h40, 32'h0);
        run_txn(gb); b_req = 1'b0;
        chk("load40", rsp_rdata, 32'h11223344);
        set_a(3'd3, 32'h41, 32'h0);
        run_txn(gb); a_req = 1'b0;
        chk("load41_err", rsp_err, 1);
        set_a(3'd3, 32'h200, 32'h0);
        run_txn(gb); a_req = 1'b0;
        chk("load200_err", rsp_err, 1);
        chk("load_err_rdata", rsp_rdata, 0);
        set_a(3'd7, 32'h0, 32'h0);
        run_txn(gb); a_req = 1'b0;

        // Randomized mix; a losing request stays held unchanged
        for (int i = 0; i < 150; i++) begin
            if (!a_req) begin
                a_req = 1'($urandom_range(0, 1));
                a_op = rand_op(); a_addr = rand_addr();
                a_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h208));
            end
            if (!b_req) begin
                b_req = 1'($urandom_range(0, 1));
                b_op = rand_op(); b_addr = rand_addr();
                b_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h208));
            end
            if (!a_req && !b_req) a_req = 1'b1;
            run_txn(gb);
            if (gb) b_req = 1'b0;
            else    a_req = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;

        // SETESP, then reset during EXEC of a PUSH
        set_a(3'd5, 32'h0, 32'h100);
        run_txn(gb); a_req = 1'b0;
        chk("setesp", esp, 32'h100);
        saved = tb_mem[63];
        set_a(3'd1, 32'h0, 32'hCAFEF00D);
        @(posedge clock); #1;
        chk("abort_exec_op", mem_op, 4'h1);
        reset = 1'b1;
        #1;
        chk("abort_gated_op", mem_op, 0);
        @(posedge clock); #1;
        a_req = 1'b0; reset = 1'b0;
        model_reset();
        chk("abort_a_ack", a_ack, 0);
        chk("abort_esp", esp, 32'h200);
        chk("abort_busy", busy, 0);
        chk("abort_mem_op", mem_op, 0);
        chk("abort_no_write", tb_mem[63], saved);
        @(posedge clock); #1;
        chk("abort_ack_later", a_ack, 0);
        chk("abort_idle", busy, 0);

        // Fairness state cleared by reset: B wins first even with A present
        set_a(3'd1, 32'h0, 32'h0A0A0A0A);
        set_b(3'd1, 32'h0, 32'h0B0B0B0B);
        run_txn(gb);
        chk("post_rst_b_first", gb, 1);
        b_req = 1'b0;
        run_txn(gb); a_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
